// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for alu_seq.
//   Request : in_valid, in_ready, op[4:0], a, b
//   Response: out_valid, out_ready, result, z, iqf
//   Status  : busy
// master is the core (stage driving requests, taking results), slave is
// the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             z;
  logic             iqf;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, z, iqf, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, z, iqf, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU. Base RV32I ops complete with one cycle
// of registered latency; RV32M multiply/divide/remainder iterate over
// WIDTH cycles (shift-add multiply, restoring divide, both on magnitudes).
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   bus       alu_seq_if.slave (request, response, busy)
//   dbg_state current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a request is taken on a rising edge where in_valid and
// in_ready are both 1; a result is handed over on a rising edge where
// out_valid and out_ready are both 1. in_ready, out_valid and busy are
// decoded from the state register only, and result/z/iqf are flops, so
// no input reaches an output combinationally.
module alu_seq #(
  parameter int          WIDTH  = 32,
  parameter logic [31:0] ID_KEY = 32'h00003EE2
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] KEY     = WIDTH'(ID_KEY);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2:0]         mop_q, mop_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               z_q, z_d;
  logic               iqf_q, iqf_d;

  // ---------------------------------------------------------------------
  // Base ALU, evaluated on the live request and only used at accept.
  // ---------------------------------------------------------------------
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] base_res;
  logic             base_iqf;
  logic             base_zok;

  assign shamt = bus.b[SW-1:0];

  always_comb begin
    base_res = '0;
    base_iqf = 1'b0;
    base_zok = 1'b1;
    case (bus.op[3:0])
      4'd0:  base_res = bus.a + bus.b;
      4'd1:  base_res = bus.a - bus.b;
      4'd2:  base_res = bus.a | bus.b;
      4'd3:  base_res = bus.a & bus.b;
      4'd4:  base_res = bus.a ^ bus.b;
      4'd5:  base_res = bus.a << shamt;
      4'd6:  base_res = bus.a >> shamt;
      4'd7:  base_res = $signed(bus.a) >>> shamt;
      4'd8:  base_iqf = $signed(bus.a) <  $signed(bus.b);
      4'd9:  base_iqf = bus.a <  bus.b;
      4'd10: base_iqf = $signed(bus.a) >= $signed(bus.b);
      4'd11: base_iqf = bus.a >= bus.b;
      4'd12: base_res = bus.a ^ KEY;
      // Undefined codes report a zero result without raising z.
      default: base_zok = 1'b0;
    endcase
    if (bus.op[3:2] == 2'b10) begin
      base_res = {{(WIDTH-1){1'b0}}, base_iqf};
    end
  end

  // ---------------------------------------------------------------------
  // M-op decode at accept: operand signs, magnitudes, special cases.
  // ---------------------------------------------------------------------
  logic [2:0]       mf;
  logic             sdiv;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div0, ovf;
  logic [WIDTH-1:0] spec_res;

  assign mf = bus.op[2:0];

  always_comb begin
    sdiv = (mf == 3'd4) || (mf == 3'd6);
    if (mf[2]) begin
      sa = sdiv & bus.a[WIDTH-1];
      sb = sdiv & bus.b[WIDTH-1];
    end else begin
      // MUL takes the low half, which is sign-agnostic; treat as unsigned.
      sa = ((mf == 3'd1) || (mf == 3'd2)) & bus.a[WIDTH-1];
      sb = (mf == 3'd1) & bus.b[WIDTH-1];
    end
    mag_a    = sa ? -bus.a : bus.a;
    mag_b    = sb ? -bus.b : bus.b;
    div0     = mf[2] && (bus.b == '0);
    ovf      = sdiv && (bus.a == MIN_NEG) && (bus.b == '1);
    spec_res = '0;
    if (div0) begin
      spec_res = mf[1] ? bus.a : '1;
    end else if (ovf) begin
      spec_res = mf[1] ? '0 : bus.a;
    end
  end

  // ---------------------------------------------------------------------
  // One iteration step and the sign-corrected final value.
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_sel;
  logic [WIDTH-1:0]   fin;

  always_comb begin
    // Multiply: acc = {partial high, remaining multiplier bits}; add the
    // multiplicand into the high half when the low bit is set, then shift.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH-1:1]};
    // Divide: acc = {remainder, dividend/quotient}; shift left one bit and
    // keep the trial subtraction when it does not borrow.
    div_sh   = {acc_q, 1'b0};
    div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    div_next = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                               : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
    step     = mop_q[2] ? div_next : mul_next;

    prod     = neg_q ? -step : step;
    div_sel  = mop_q[1] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    if (mop_q[2]) begin
      fin = neg_q ? -div_sel : div_sel;
    end else if (mop_q[1:0] == 2'd0) begin
      fin = prod[WIDTH-1:0];
    end else begin
      fin = prod[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    mop_d    = mop_q;
    neg_d    = neg_q;
    result_d = result_q;
    z_d      = z_q;
    iqf_d    = iqf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (!bus.op[4]) begin
            result_d = base_res;
            z_d      = base_zok && (base_res == '0);
            iqf_d    = base_iqf;
            state_d  = S_DONE;
          end else if (div0 || ovf) begin
            result_d = spec_res;
            z_d      = (spec_res == '0);
            iqf_d    = 1'b0;
            state_d  = S_DONE;
          end else begin
            acc_d   = mf[2] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            opnd_d  = mf[2] ? mag_b : mag_a;
            mop_d   = mf;
            // Quotient sign is sa^sb; remainder sign follows the dividend.
            neg_d   = (mf[2] && mf[1]) ? sa : (sa ^ sb);
            cnt_d   = CW'(WIDTH);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
        // The last of the WIDTH steps lands directly in the result flops.
        if (cnt_q == CW'(1)) begin
          result_d = fin;
          z_d      = (fin == '0);
          iqf_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      mop_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      iqf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      mop_q    <= mop_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      z_q      <= z_d;
      iqf_q    <= iqf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_BUSY);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.z         = z_q;
  assign bus.iqf       = iqf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq at WIDTH=32 (hand-computed
// vectors) and WIDTH=16 (M ops against a behavioural reference).
module tb_alu_seq;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_GEQ   = 5'd10;
  localparam logic [4:0] OP_GEQU  = 5'd11;
  localparam logic [4:0] OP_XORID = 5'd12;
  localparam logic [4:0] OP_UND13 = 5'd13;
  localparam logic [4:0] OP_MUL   = 5'h10;
  localparam logic [4:0] OP_MULH  = 5'h11;
  localparam logic [4:0] OP_MULHS = 5'h12;
  localparam logic [4:0] OP_MULHU = 5'h13;
  localparam logic [4:0] OP_DIV   = 5'h14;
  localparam logic [4:0] OP_DIVU  = 5'h15;
  localparam logic [4:0] OP_REM   = 5'h16;
  localparam logic [4:0] OP_REMU  = 5'h17;

  localparam logic [2:0]  V16_F [12] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd6,
                                         3'd5, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [15:0] V16_A [12] = '{16'h8000, 16'hFFFD, 16'hFFFF, 16'hFFFF,
                                         16'hFFF9, 16'hFFF9, 16'h0064, 16'h0064,
                                         16'h8000, 16'h1234, 16'h8000, 16'hABCD};
  localparam logic [15:0] V16_B [12] = '{16'h8000, 16'h0007, 16'h0002, 16'hFFFF,
                                         16'h0002, 16'h0002, 16'h0007, 16'h0007,
                                         16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) b32 ();
  alu_seq_if #(.WIDTH(16)) b16 ();
  logic [1:0] dbg32, dbg16;

  alu_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(b32.slave), .dbg_state(dbg32));
  alu_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(b16.slave), .dbg_state(dbg16));

  int checks   = 0;
  int failures = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_res(input bit w16);
    return w16 ? {16'h0, b16.result} : b32.result;
  endfunction

  function automatic logic get_valid(input bit w16);
    return w16 ? b16.out_valid : b32.out_valid;
  endfunction

  function automatic logic get_ready(input bit w16);
    return w16 ? b16.in_ready : b32.in_ready;
  endfunction

  function automatic logic get_busy(input bit w16);
    return w16 ? b16.busy : b32.busy;
  endfunction

  // driver tasks
  task automatic start_op(input bit w16, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    if (w16) begin
      b16.op = op; b16.a = a[15:0]; b16.b = b[15:0]; b16.in_valid = 1'b1;
    end else begin
      b32.op = op; b32.a = a; b32.b = b; b32.in_valid = 1'b1;
    end
    tick();
    // Operands must have been captured at accept.
    b16.in_valid = 1'b0; b16.a = 16'($urandom()); b16.b = 16'($urandom());
    b32.in_valid = 1'b0; b32.a = $urandom();      b32.b = $urandom();
  endtask

  task automatic wait_done(input bit w16, output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (1) begin
      if (get_busy(w16)) busy_n++;
      if (get_valid(w16) || lat >= 200) break;
      tick();
      lat++;
    end
  endtask

  task automatic finish_op(input bit w16);
    if (w16) b16.out_ready = 1'b1; else b32.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
    b32.out_ready = 1'b0;
  endtask

  task automatic run_op(input bit w16, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_z,
                        input logic exp_iqf, input int exp_lat, input string tag);
    int lat, busy_n;
    check($sformatf("%s.ready_pre", tag), get_ready(w16), 1);
    start_op(w16, op, a, b);
    wait_done(w16, lat, busy_n);
    check($sformatf("%s.lat", tag), lat, exp_lat);
    check($sformatf("%s.busy_cycles", tag), busy_n, exp_lat - 1);
    check($sformatf("%s.result", tag), get_res(w16), exp_res);
    check($sformatf("%s.z", tag), w16 ? b16.z : b32.z, exp_z);
    check($sformatf("%s.iqf", tag), w16 ? b16.iqf : b32.iqf, exp_iqf);
    check($sformatf("%s.ready_low", tag), get_ready(w16), 0);
    finish_op(w16);
    check($sformatf("%s.ready_post", tag), get_ready(w16), 1);
    check($sformatf("%s.valid_post", tag), get_valid(w16), 0);
  endtask

  // reference for 16-bit M ops
  function automatic logic [15:0] ref16(input logic [2:0] f, input logic [15:0] a,
                                        input logic [15:0] b);
    longint sa, sb, ua, ub, r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 16'h8000) && (b == 16'hFFFF);
    case (f)
      3'd0:    r = sa * sb;
      3'd1:    r = (sa * sb) >>> 16;
      3'd2:    r = (sa * ub) >>> 16;
      3'd3:    r = (ua * ub) >>> 16;
      3'd4:    r = (b == 0) ? -1 : (ovf ? sa : sa / sb);
      3'd5:    r = (b == 0) ? -1 : ua / ub;
      3'd6:    r = (b == 0) ? sa : (ovf ? 0 : sa % sb);
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[15:0];
  endfunction

  initial begin
    int lat, busy_n;
    logic [15:0] r16;
    logic [2:0]  f;
    bit          spec;

    reset = 1'b1;
    b32.in_valid = 1'b0; b32.op = '0; b32.a = '0; b32.b = '0; b32.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.op = '0; b16.a = '0; b16.b = '0; b16.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    check("rst.ready", b32.in_ready, 1);
    check("rst.valid", b32.out_valid, 0);
    check("rst.busy", b32.busy, 0);
    check("rst.result", b32.result, 0);
    check("rst.z", b32.z, 0);
    check("rst.iqf", b32.iqf, 0);
    check("rst.state", dbg32, 0);
    check("rst16.ready", b16.in_ready, 1);

    // base ops, WIDTH=32
    run_op(0, OP_ADD,   32'd5,        32'hFFFFFFFB, 32'h0,        1, 0, 1, "add");
    run_op(0, OP_SUB,   32'd3,        32'd5,        32'hFFFFFFFE, 0, 0, 1, "sub");
    run_op(0, OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        0, 1, 1, "slt");
    run_op(0, OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 1, "sltu");
    run_op(0, OP_GEQ,   32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 1, "geq");
    run_op(0, OP_GEQU,  32'hFFFFFFFF, 32'd1,        32'd1,        0, 1, 1, "gequ");
    run_op(0, OP_SRA,   32'h80000000, 32'd31,       32'hFFFFFFFF, 0, 0, 1, "sra");
    run_op(0, OP_SLL,   32'd1,        32'd33,       32'd2,        0, 0, 1, "sll_mask");
    run_op(0, OP_XORID, 32'h0000FFFF, 32'd0,        32'h0000C11D, 0, 0, 1, "xorid");
    run_op(0, OP_UND13, 32'd0,        32'd0,        32'd0,        0, 0, 1, "undef13");

    // M ops, WIDTH=32
    run_op(0, OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 33, "mulh");
    run_op(0, OP_MUL,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 0, 0, 33, "mul");
    run_op(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 33, "mulhu");
    run_op(0, OP_MULHS, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 0, 33, "mulhsu");
    run_op(0, OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 33, "div");
    run_op(0, OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0, 33, "rem");
    run_op(0, OP_REMU,  32'd100,      32'd7,        32'd2,        0, 0, 33, "remu");
    run_op(0, OP_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 0, 0, 1,  "divu_by0");
    run_op(0, OP_REM,   32'd5,        32'd0,        32'd5,        0, 0, 1,  "rem_by0");
    run_op(0, OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0, 1,  "rem_ovf");
    run_op(0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 1,  "div_ovf");

    // backpressure: DIVU 100/7 held in DONE with inputs wiggling
    start_op(0, OP_DIVU, 32'd100, 32'd7);
    wait_done(0, lat, busy_n);
    check("bp.lat", lat, 33);
    for (int i = 0; i < 10; i++) begin
      b32.in_valid = i[0];
      b32.a        = $urandom();
      b32.b        = $urandom();
      tick();
      check($sformatf("bp.result%0d", i), b32.result, 32'd14);
      check($sformatf("bp.ready%0d", i), b32.in_ready, 0);
      check($sformatf("bp.valid%0d", i), b32.out_valid, 1);
    end
    b32.in_valid = 1'b0;
    finish_op(0);
    check("bp.ready_post", b32.in_ready, 1);
    check("bp.state_post", dbg32, 0);
    tick();
    check("bp.not_latched", b32.out_valid, 0);

    // reset in the middle of an iteration
    start_op(0, OP_MULHU, 32'hDEADBEEF, 32'h12345678);
    repeat (4) tick();
    check("mr.busy_before", b32.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr.state", dbg32, 0);
    check("mr.valid", b32.out_valid, 0);
    check("mr.busy", b32.busy, 0);
    check("mr.result", b32.result, 0);
    check("mr.ready", b32.in_ready, 1);
    run_op(0, OP_ADD, 32'd1, 32'd2, 32'd3, 0, 0, 1, "add_after_rst");

    // M ops, WIDTH=16
    for (int i = 0; i < 12; i++) begin
      f    = V16_F[i];
      r16  = ref16(f, V16_A[i], V16_B[i]);
      spec = f[2] && ((V16_B[i] == 16'h0) ||
                      (!f[0] && V16_A[i] == 16'h8000 && V16_B[i] == 16'hFFFF));
      run_op(1, {2'b10, f}, {16'h0, V16_A[i]}, {16'h0, V16_B[i]}, {16'h0, r16},
             r16 == 16'h0, 0, spec ? 1 : 17, $sformatf("w16_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. Executes the base RV32I integer operations with one cycle of registered latency. Adds the RV32M multiply, divide and remainder operations, computed iteratively over WIDTH cycles. Sits between the register-read stage and writeback in the multi-cycle core, behind a valid/ready handshake so the core can stall on long operations.

## Interface
- WIDTH, 32: operand/result width; any value ≥ 8; shift amounts use the low $clog2(WIDTH) bits of b.
- ID_KEY, 32'h00003EE2: constant for XORID, truncated/zero-extended to WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- op  in  5  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- z  out  1  registered: result == 0.
- iqf  out  1  registered: comparison true (SLT/SLTU/GEQ/GEQU only, else 0).
- busy  out  1  iterative operation in progress.

## Operation
- Base ops, op[4]=0: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 GEQ, 11 GEQU, 12 XORID (a ^ ID_KEY). Comparisons give result 1/0 with iqf equal to result.
- Codes 13–15 give result 0, z=0, iqf=0 and complete as base ops.
- M ops, op[4]=1, op[2:0]: 0 MUL (low WIDTH), 1 MULH (s×s high), 2 MULHSU (s×u high), 3 MULHU (u×u high), 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Multiply: shift-add on operand magnitudes over a 2·WIDTH accumulator, sign-corrected at the end.
- Divide: restoring, one quotient bit per cycle, on magnitudes. Quotient sign is sa^sb; remainder sign follows the dividend.
- Special cases, detected at accept and completed without iterating:
  - Divide by zero: quotient all ones; remainder = a.
  - Signed overflow (a = most-negative, b = −1): quotient = a; remainder = 0.
- Operands are captured at accept; a and b may change afterwards.
- FSM:
  - IDLE: in_ready=1. Accept on in_valid. A base op or special case goes to DONE. Any other M op loads the iteration counter with WIDTH and goes to BUSY.
  - BUSY: busy=1, in_ready=0. Counter decrements each cycle; at 0, result is written and the FSM goes to DONE.
  - DONE: out_valid=1, in_ready=0. When out_ready=1, go to IDLE. result, z and iqf stay stable until the handshake completes.
- Reset: in any state (including mid-iteration), the next edge gives state IDLE, result=0, z=0, iqf=0, out_valid=0, busy=0, in_ready=1. Partial work is discarded.

## Timing
- Accept edge: in_valid & in_ready.
- Base op or special case: out_valid=1 in the cycle after the accept edge (latency 1).
- Iterative M op: out_valid=1 WIDTH+1 cycles after the accept edge. busy is high for exactly WIDTH cycles.
- in_ready returns to 1 in the cycle after out_valid & out_ready. There are no back-to-back accepts, so peak throughput is one op per 2 cycles.
- out_ready held low keeps DONE indefinitely with outputs frozen.
- in_valid while in_ready=0 is ignored, and the request is not latched.
- No combinational path from in_valid/op/a/b to any output. in_ready depends only on state.

## Test plan
- Reset, then ADD a=5, b=−5 (WIDTH=32) → out_valid in the cycle after accept; result=0, z=1, iqf=0; in_ready=1 in the cycle after out_ready.
- SLT a=−1, b=1 → result=1, iqf=1. SLTU with the same operands → result=0, iqf=0, z=1. SRA a=0x80000000, b=31 → 0xFFFFFFFF.
- MULH a=0x80000000, b=0x80000000 → result 0x40000000 exactly 33 cycles after accept; busy high for 32 cycles. MUL a=−3, b=7 → 0xFFFFFFEB.
- DIV a=−7, b=2 → −3; REM → −1. DIVU a=7, b=0 → 0xFFFFFFFF with latency 1. REM a=0x80000000, b=−1 → 0 with latency 1.
- Backpressure: finish DIVU 100/7, hold out_ready=0 for 10 cycles while toggling a, b, in_valid → result stays 14, in_ready stays 0; on out_ready=1 it returns to IDLE.
- Assert reset 5 cycles into a MULHU → next cycle IDLE, out_valid=0, busy=0, result=0. A following ADD 1+2 → 3.
- Repeat the M-op tests with WIDTH=16 against a reference model: latency is 17 cycles.
